exc_redirect_ctrl: RTL and testbench



---
 rtl/cpu_defs_pkg.sv | 29 ++
 rtl/exc_redirect_ctrl_prio_enc.sv | 44 ++++
 rtl/exc_redirect_ctrl.sv | 122 ++++++++++++
 tb/tb_exc_redirect_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared core definitions: exception codes, writeback exception-vector bit
// positions and the small enums used by the commit-point redirect logic.
package cpu_defs;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_INE  = 6'h0D;

    localparam int EXC_SYS  = 0;
    localparam int EXC_BRK  = 1;
    localparam int EXC_INE  = 2;
    localparam int EXC_ALE  = 3;
    localparam int EXC_ADEF = 4;

    typedef enum logic [1:0] {
        BADV_NONE  = 2'd0,
        BADV_PC    = 2'd1,
        BADV_VADDR = 2'd2
    } badv_sel_e;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_REDIRECT = 1'b1
    } redir_state_e;

endpackage

// File: rtl/exc_redirect_ctrl_prio_enc.sv
// Combinational cause priority encoder: picks the winning exception among
// the pending interrupt and the writeback cause bits.
module exc_prio_enc
    import cpu_defs::*;
#(
    parameter int EXC_W = 6
) (
    input  logic [EXC_W-1:0] wb_exc,
    input  logic             has_int,
    output logic             exc_hit,
    output logic [5:0]       ecode,
    output logic [8:0]       esubcode,
    output logic [1:0]       badv_sel
);

    // Bits above ADEF are reserved and never raise an exception.
    logic unused_exc_bits;
    assign unused_exc_bits = ^wb_exc;

    always_comb begin
        exc_hit  = 1'b1;
        ecode    = 6'd0;
        esubcode = 9'd0;
        badv_sel = BADV_NONE;
        if (has_int) begin
            ecode = ECODE_INT;
        end else if (wb_exc[EXC_ADEF]) begin
            ecode    = ECODE_ADEF;
            badv_sel = BADV_PC;
        end else if (wb_exc[EXC_INE]) begin
            ecode = ECODE_INE;
        end else if (wb_exc[EXC_SYS]) begin
            ecode = ECODE_SYS;
        end else if (wb_exc[EXC_BRK]) begin
            ecode = ECODE_BRK;
        end else if (wb_exc[EXC_ALE]) begin
            ecode    = ECODE_ALE;
            badv_sel = BADV_VADDR;
        end else begin
            exc_hit = 1'b0;
        end
    end

endmodule

// File: rtl/exc_redirect_ctrl.sv
// Commit-point exception / ERTN sequencer: cancels the pipeline, issues one
// CSR update command and holds a fetch redirect until pre-IF accepts it.
module exc_redirect_ctrl
    import cpu_defs::*;
#(
    parameter int PC_W  = 32,
    parameter int EXC_W = 6
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             wb_valid,
    input  logic [EXC_W-1:0] wb_exc,
    input  logic             ertn_flush,
    input  logic [PC_W-1:0]  wb_pc,
    input  logic [PC_W-1:0]  wb_fault_vaddr,
    input  logic             has_int,
    input  logic [PC_W-1:0]  csr_eentry,
    input  logic [PC_W-1:0]  csr_era,
    input  logic             redirect_ready,
    output logic             cancel_exc_ertn,
    output logic             exc_commit,
    output logic [5:0]       exc_ecode,
    output logic [8:0]       exc_esubcode,
    output logic [PC_W-1:0]  exc_era,
    output logic             exc_badv_we,
    output logic [PC_W-1:0]  exc_badv,
    output logic             ertn_commit,
    output logic             redirect_valid,
    output logic [PC_W-1:0]  redirect_pc,
    output logic             fetch_hold
);

    redir_state_e    state_q, state_d;
    logic [PC_W-1:0] redirect_pc_q, redirect_pc_d;

    logic       take_int, take_exc, take_ertn;
    logic       in_idle, exc_fire, ertn_fire;
    logic       enc_hit;
    logic [5:0] enc_ecode;
    logic [8:0] enc_esubcode;
    logic [1:0] enc_badv_sel;

    exc_prio_enc #(
        .EXC_W (EXC_W)
    ) u_prio_enc (
        .wb_exc   (wb_exc),
        .has_int  (take_int),
        .exc_hit  (enc_hit),
        .ecode    (enc_ecode),
        .esubcode (enc_esubcode),
        .badv_sel (enc_badv_sel)
    );

    // Interrupts are only taken on a retiring instruction so ERA has a real PC.
    assign take_int  = wb_valid & has_int;
    assign take_exc  = enc_hit;
    assign take_ertn = ertn_flush & ~take_exc;

    // resetn gating keeps the combinational strobes quiet while in reset.
    assign in_idle   = resetn & (state_q == ST_IDLE);
    assign exc_fire  = in_idle & take_exc;
    assign ertn_fire = in_idle & take_ertn;

    always_comb begin
        cancel_exc_ertn = exc_fire | ertn_fire;
        exc_commit      = exc_fire;
        ertn_commit     = ertn_fire;
        exc_ecode       = 6'd0;
        exc_esubcode    = 9'd0;
        exc_era         = '0;
        exc_badv_we     = 1'b0;
        exc_badv        = '0;
        if (exc_fire) begin
            exc_ecode    = enc_ecode;
            exc_esubcode = enc_esubcode;
            exc_era      = wb_pc;
            exc_badv_we  = (enc_badv_sel != BADV_NONE);
            if (enc_badv_sel == BADV_PC) begin
                exc_badv = wb_pc;
            end else if (enc_badv_sel == BADV_VADDR) begin
                exc_badv = wb_fault_vaddr;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        redirect_pc_d = redirect_pc_q;
        case (state_q)
            ST_IDLE: begin
                if (exc_fire) begin
                    state_d       = ST_REDIRECT;
                    redirect_pc_d = csr_eentry;
                end else if (ertn_fire) begin
                    state_d       = ST_REDIRECT;
                    redirect_pc_d = csr_era;
                end
            end
            ST_REDIRECT: begin
                if (redirect_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            redirect_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign redirect_valid = (state_q == ST_REDIRECT);
    assign fetch_hold     = (state_q == ST_REDIRECT);
    assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_exc_redirect_ctrl.sv
// Directed bench for exc_redirect_ctrl: inputs change on the falling edge,
// outputs are sampled 1 time unit later, well away from the rising edge.
module tb_exc_redirect_ctrl;

    localparam int PC_W  = 32;
    localparam int EXC_W = 6;

    logic             clk = 1'b0;
    logic             resetn;
    logic             wb_valid;
    logic [EXC_W-1:0] wb_exc;
    logic             ertn_flush;
    logic [PC_W-1:0]  wb_pc;
    logic [PC_W-1:0]  wb_fault_vaddr;
    logic             has_int;
    logic [PC_W-1:0]  csr_eentry;
    logic [PC_W-1:0]  csr_era;
    logic             redirect_ready;
    logic             cancel_exc_ertn;
    logic             exc_commit;
    logic [5:0]       exc_ecode;
    logic [8:0]       exc_esubcode;
    logic [PC_W-1:0]  exc_era;
    logic             exc_badv_we;
    logic [PC_W-1:0]  exc_badv;
    logic             ertn_commit;
    logic             redirect_valid;
    logic [PC_W-1:0]  redirect_pc;
    logic             fetch_hold;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    exc_redirect_ctrl #(.PC_W(PC_W), .EXC_W(EXC_W)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .wb_valid        (wb_valid),
        .wb_exc          (wb_exc),
        .ertn_flush      (ertn_flush),
        .wb_pc           (wb_pc),
        .wb_fault_vaddr  (wb_fault_vaddr),
        .has_int         (has_int),
        .csr_eentry      (csr_eentry),
        .csr_era         (csr_era),
        .redirect_ready  (redirect_ready),
        .cancel_exc_ertn (cancel_exc_ertn),
        .exc_commit      (exc_commit),
        .exc_ecode       (exc_ecode),
        .exc_esubcode    (exc_esubcode),
        .exc_era         (exc_era),
        .exc_badv_we     (exc_badv_we),
        .exc_badv        (exc_badv),
        .ertn_commit     (ertn_commit),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .fetch_hold      (fetch_hold)
    );

    task automatic clear_wb();
        wb_valid   = 1'b0;
        wb_exc     = '0;
        ertn_flush = 1'b0;
        has_int    = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        clear_wb();
        wb_pc = 32'h1C000000; wb_fault_vaddr = '0;
        csr_eentry = 32'h1C008000; csr_era = '0; redirect_ready = 1'b1;
        wb_valid = 1'b1; wb_exc = 6'b000001;
        @(negedge clk); #1;
        n_checks++; if (cancel_exc_ertn !== 1'b0) begin n_fail++; $display("FAIL rst_cancel: got %0b want 0", cancel_exc_ertn); end
        n_checks++; if (exc_commit !== 1'b0) begin n_fail++; $display("FAIL rst_exc_commit: got %0b want 0", exc_commit); end
        n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL rst_redirect_valid: got %0b want 0", redirect_valid); end
        n_checks++; if (redirect_pc !== 32'h0) begin n_fail++; $display("FAIL rst_redirect_pc: got %h want 0", redirect_pc); end
        n_checks++; if (fetch_hold !== 1'b0) begin n_fail++; $display("FAIL rst_fetch_hold: got %0b want 0", fetch_hold); end
        clear_wb();
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_sys();
        wb_valid = 1'b1; wb_exc = 6'b000001; wb_pc = 32'h1C000100;
        csr_eentry = 32'h1C008000; redirect_ready = 1'b1;
        #1;
        n_checks++; if (cancel_exc_ertn !== 1'b1) begin n_fail++; $display("FAIL sys_cancel: got %0b want 1", cancel_exc_ertn); end
        n_checks++; if (exc_commit !== 1'b1) begin n_fail++; $display("FAIL sys_commit: got %0b want 1", exc_commit); end
        n_checks++; if (exc_ecode !== 6'h0B) begin n_fail++; $display("FAIL sys_ecode: got %h want 0b", exc_ecode); end
        n_checks++; if (exc_era !== 32'h1C000100) begin n_fail++; $display("FAIL sys_era: got %h want 1c000100", exc_era); end
        n_checks++; if (exc_badv_we !== 1'b0) begin n_fail++; $display("FAIL sys_badv_we: got %0b want 0", exc_badv_we); end
        n_checks++; if (ertn_commit !== 1'b0) begin n_fail++; $display("FAIL sys_ertn_commit: got %0b want 0", ertn_commit); end
        n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL sys_rv_T: got %0b want 0", redirect_valid); end
        @(negedge clk);
        clear_wb();
        #1;
        n_checks++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL sys_rv_T1: got %0b want 1", redirect_valid); end
        n_checks++; if (fetch_hold !== 1'b1) begin n_fail++; $display("FAIL sys_hold_T1: got %0b want 1", fetch_hold); end
        n_checks++; if (redirect_pc !== 32'h1C008000) begin n_fail++; $display("FAIL sys_pc: got %h want 1c008000", redirect_pc); end
        n_checks++; if (exc_commit !== 1'b0) begin n_fail++; $display("FAIL sys_commit_T1: got %0b want 0", exc_commit); end
        @(negedge clk); #1;
        n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL sys_rv_T2: got %0b want 0", redirect_valid); end
        n_checks++; if (fetch_hold !== 1'b0) begin n_fail++; $display("FAIL sys_hold_T2: got %0b want 0", fetch_hold); end
        @(negedge clk);
    endtask

    task automatic test_ale();
        int rv_cycles;
        rv_cycles = 0;
        wb_valid = 1'b1; wb_exc = 6'b001000; wb_pc = 32'h1C000180;
        wb_fault_vaddr = 32'h00001003; csr_eentry = 32'h1C008000; redirect_ready = 1'b0;
        #1;
        n_checks++; if (exc_ecode !== 6'h09) begin n_fail++; $display("FAIL ale_ecode: got %h want 09", exc_ecode); end
        n_checks++; if (exc_badv_we !== 1'b1) begin n_fail++; $display("FAIL ale_badv_we: got %0b want 1", exc_badv_we); end
        n_checks++; if (exc_badv !== 32'h00001003) begin n_fail++; $display("FAIL ale_badv: got %h want 00001003", exc_badv); end
        n_checks++; if (exc_esubcode !== 9'd0) begin n_fail++; $display("FAIL ale_esub: got %h want 0", exc_esubcode); end
        @(negedge clk);
        clear_wb();
        csr_eentry = 32'hDEAD0000;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) redirect_ready = 1'b1;
            #1;
            if (redirect_valid === 1'b1) rv_cycles++;
            n_checks++; if (redirect_pc !== 32'h1C008000) begin n_fail++; $display("FAIL ale_pc_stable[%0d]: got %h want 1c008000", i, redirect_pc); end
            @(negedge clk);
        end
        #1;
        n_checks++; if (rv_cycles != 4) begin n_fail++; $display("FAIL ale_rv_cycles: got %0d want 4", rv_cycles); end
        n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL ale_rv_after: got %0b want 0", redirect_valid); end
        @(negedge clk);
    endtask

    task automatic test_ertn();
        wb_valid = 1'b1; ertn_flush = 1'b1; wb_pc = 32'h1C000500;
        csr_era = 32'h1C000200; csr_eentry = 32'h1C008000; redirect_ready = 1'b1;
        #1;
        n_checks++; if (ertn_commit !== 1'b1) begin n_fail++; $display("FAIL ertn_commit: got %0b want 1", ertn_commit); end
        n_checks++; if (exc_commit !== 1'b0) begin n_fail++; $display("FAIL ertn_exc_commit: got %0b want 0", exc_commit); end
        n_checks++; if (cancel_exc_ertn !== 1'b1) begin n_fail++; $display("FAIL ertn_cancel: got %0b want 1", cancel_exc_ertn); end
        @(negedge clk);
        clear_wb();
        csr_era = 32'h0;
        #1;
        n_checks++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL ertn_rv: got %0b want 1", redirect_valid); end
        n_checks++; if (redirect_pc !== 32'h1C000200) begin n_fail++; $display("FAIL ertn_pc: got %h want 1c000200", redirect_pc); end
        n_checks++; if (ertn_commit !== 1'b0) begin n_fail++; $display("FAIL ertn_commit_T1: got %0b want 0", ertn_commit); end
        @(negedge clk); #1;
        n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL ertn_rv_T2: got %0b want 0", redirect_valid); end
        @(negedge clk);
    endtask

    task automatic test_int();
        wb_valid = 1'b1; has_int = 1'b1; wb_exc = 6'b010001; wb_pc = 32'h00000040;
        csr_eentry = 32'h1C008000; redirect_ready = 1'b0;
        #1;
        n_checks++; if (exc_commit !== 1'b1) begin n_fail++; $display("FAIL int_commit: got %0b want 1", exc_commit); end
        n_checks++; if (exc_ecode !== 6'h00) begin n_fail++; $display("FAIL int_ecode: got %h want 00", exc_ecode); end
        n_checks++; if (exc_badv_we !== 1'b0) begin n_fail++; $display("FAIL int_badv_we: got %0b want 0", exc_badv_we); end
        n_checks++; if (exc_era !== 32'h40) begin n_fail++; $display("FAIL int_era: got %h want 00000040", exc_era); end
        @(negedge clk); #1;
        n_checks++; if (exc_commit !== 1'b0) begin n_fail++; $display("FAIL int_second_commit: got %0b want 0", exc_commit); end
        n_checks++; if (cancel_exc_ertn !== 1'b0) begin n_fail++; $display("FAIL int_second_cancel: got %0b want 0", cancel_exc_ertn); end
        clear_wb();
        redirect_ready = 1'b1;
        @(negedge clk); #1;
        n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL int_rv_after: got %0b want 0", redirect_valid); end
        @(negedge clk);
    endtask

    task automatic test_ertn_ine();
        wb_valid = 1'b1; ertn_flush = 1'b1; wb_exc = 6'b000100; wb_pc = 32'h1C000600;
        csr_eentry = 32'h1C00A000; csr_era = 32'h1C000300; redirect_ready = 1'b1;
        #1;
        n_checks++; if (exc_commit !== 1'b1) begin n_fail++; $display("FAIL ine_commit: got %0b want 1", exc_commit); end
        n_checks++; if (exc_ecode !== 6'h0D) begin n_fail++; $display("FAIL ine_ecode: got %h want 0d", exc_ecode); end
        n_checks++; if (ertn_commit !== 1'b0) begin n_fail++; $display("FAIL ine_ertn_commit: got %0b want 0", ertn_commit); end
        @(negedge clk);
        clear_wb();
        #1;
        n_checks++; if (redirect_pc !== 32'h1C00A000) begin n_fail++; $display("FAIL ine_pc: got %h want 1c00a000", redirect_pc); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        wb_valid = 1'b1; wb_exc = 6'b000010; wb_pc = 32'h1C000400;
        csr_eentry = 32'h1C00B000; redirect_ready = 1'b1;
        #1;
        n_checks++; if (exc_ecode !== 6'h0C) begin n_fail++; $display("FAIL b2b_brk_ecode: got %h want 0c", exc_ecode); end
        @(negedge clk);
        clear_wb();
        @(negedge clk);
        wb_valid = 1'b1; wb_exc = 6'b010000; wb_pc = 32'h1C000404;
        csr_eentry = 32'h1C00C000;
        #1;
        n_checks++; if (exc_commit !== 1'b1) begin n_fail++; $display("FAIL b2b_commit: got %0b want 1", exc_commit); end
        n_checks++; if (exc_ecode !== 6'h08) begin n_fail++; $display("FAIL b2b_adef_ecode: got %h want 08", exc_ecode); end
        n_checks++; if (exc_badv_we !== 1'b1) begin n_fail++; $display("FAIL b2b_badv_we: got %0b want 1", exc_badv_we); end
        n_checks++; if (exc_badv !== 32'h1C000404) begin n_fail++; $display("FAIL b2b_badv: got %h want 1c000404", exc_badv); end
        @(negedge clk);
        clear_wb();
        #1;
        n_checks++; if (redirect_pc !== 32'h1C00C000) begin n_fail++; $display("FAIL b2b_pc: got %h want 1c00c000", redirect_pc); end
        @(negedge clk);
    endtask

    task automatic test_reserved_bit();
        wb_valid = 1'b1; wb_exc = 6'b100000; wb_pc = 32'h1C000700;
        #1;
        n_checks++; if (cancel_exc_ertn !== 1'b0) begin n_fail++; $display("FAIL rsv_cancel: got %0b want 0", cancel_exc_ertn); end
        n_checks++; if (exc_commit !== 1'b0) begin n_fail++; $display("FAIL rsv_commit: got %0b want 0", exc_commit); end
        @(negedge clk);
        clear_wb();
        #1;
        n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL rsv_rv: got %0b want 0", redirect_valid); end
        @(negedge clk);
    endtask

    task automatic test_reset_in_redirect();
        wb_valid = 1'b1; wb_exc = 6'b000001; wb_pc = 32'h1C000800;
        csr_eentry = 32'h1C00D000; redirect_ready = 1'b0;
        @(negedge clk); #1;
        n_checks++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL rr_rv: got %0b want 1", redirect_valid); end
        n_checks++; if (exc_commit !== 1'b0) begin n_fail++; $display("FAIL rr_inject_commit: got %0b want 0", exc_commit); end
        n_checks++; if (cancel_exc_ertn !== 1'b0) begin n_fail++; $display("FAIL rr_inject_cancel: got %0b want 0", cancel_exc_ertn); end
        #2;
        resetn = 1'b0;
        #1;
        n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL rr_rv_reset: got %0b want 0", redirect_valid); end
        n_checks++; if (redirect_pc !== 32'h0) begin n_fail++; $display("FAIL rr_pc_reset: got %h want 0", redirect_pc); end
        n_checks++; if (exc_commit !== 1'b0) begin n_fail++; $display("FAIL rr_commit_reset: got %0b want 0", exc_commit); end
        @(negedge clk);
        clear_wb();
        resetn = 1'b1;
        #1;
        n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL rr_rv_release: got %0b want 0", redirect_valid); end
        @(negedge clk);
        wb_valid = 1'b1; wb_exc = 6'b000001; redirect_ready = 1'b1;
        #1;
        n_checks++; if (exc_commit !== 1'b1) begin n_fail++; $display("FAIL rr_idle_commit: got %0b want 1", exc_commit); end
        @(negedge clk);
        clear_wb();
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_sys();
        test_ale();
        test_ertn();
        test_int();
        test_ertn_ine();
        test_back_to_back();
        test_reserved_bit();
        test_reset_in_redirect();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
